// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_arbiter
// Purpose  : Round-robin sharing of one NOR-flash word controller between
//            NREQ requesters, with a watchdog on each flash operation.
// Revision : 1.0  initial release
// ============================================================================
module flash_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    resp_valid,
    output logic [DW-1:0]      resp_rdata,
    output logic               resp_err,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               mem_read,
    output logic               mem_write,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               mem_done
);

    localparam int             c_CW       = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_TERM    = c_CW'(TIMEOUT - 1);
    localparam logic [1:0]     c_LAST_RST = 2'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_last;
    logic [1:0]        r_grant;
    logic [c_CW-1:0]   r_cnt;
    logic [NREQ-1:0]   r_req_ready;
    logic [NREQ-1:0]   r_resp_valid;
    logic [DW-1:0]     r_resp_rdata;
    logic              r_resp_err;
    logic              r_busy;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;

    logic              w_any;
    logic [1:0]        w_win;
    logic [NREQ-1:0]   w_win_oh;
    logic              w_win_write;
    logic [AW-1:0]     w_win_addr;
    logic [DW-1:0]     w_win_wdata;
    logic [NREQ-1:0]   w_owner_oh;
    int                w_best;
    int                w_dist;

    // Distance 0 is the requester just after the last owner; nearest pending wins.
    always_comb begin
        w_any       = 1'b0;
        w_win       = '0;
        w_win_oh    = '0;
        w_win_write = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_best      = NREQ;
        w_dist      = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_any       = 1'b1;
                w_win       = 2'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_write = req_write[i];
                w_win_addr  = req_addr[i*AW +: AW];
                w_win_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (r_grant == 2'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last       <= c_LAST_RST;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_grant     <= w_win;
                        r_req_ready <= w_win_oh;
                        r_mem_read  <= ~w_win_write;
                        r_mem_write <= w_win_write;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_req_ready <= '0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the terminal count still completes cleanly.
                    if (mem_done) begin
                        r_resp_rdata <= mem_rdata;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= w_owner_oh;
                        r_state      <= S_RESP;
                    end else if (r_cnt == c_TERM) begin
                        r_resp_rdata <= '1;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= w_owner_oh;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_RESP: begin
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_last       <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;
    assign grant_id   = r_grant;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_arbiter
// Purpose  : Self-checking bench for flash_arbiter with an in-bench flash
//            responder and a round-robin/latency reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int TO   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid, req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready, resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic               resp_err, busy;
    logic [1:0]         grant_id;
    logic               mem_read, mem_write;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_done;

    int total = 0;
    int bad   = 0;
    int exp_last = NREQ - 1;

    flash_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .grant_id(grant_id), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One flash operation: done_at = WAIT cycle (1..) in which mem_done is seen, 0 = never.
    task automatic run_op(input string tag, input int done_at, input logic [DW-1:0] rdata,
                          input bit keep, input bit spur, output int w, output int gap);
        int r;
        bit seen;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, erd;
        logic ew, eerr;
        logic [NREQ-1:0] one;
        w = -1;
        gap = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c = (exp_last + k) % NREQ;
            if (w < 0 && req_valid[c]) w = c;
        end
        if (w < 0) begin
            total++; bad++;
            $display("FAIL %s: no pending requester in stimulus", tag);
            return;
        end
        ea  = req_addr[w*AW +: AW];
        ed  = req_wdata[w*DW +: DW];
        ew  = req_write[w];
        one = NREQ'(1) << w;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            gap++;
            seen = mem_read | mem_write;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s strobe: none within 6 cycles, required requester %0d", tag, w);
            return;
        end
        total++;
        if ({req_ready, grant_id, mem_addr, mem_wdata, mem_write, mem_read, busy, resp_valid} !==
            {one, 2'(w), ea, ed, ew, ~ew, 1'b1, {NREQ{1'b0}}}) begin
            bad++;
            $display("FAIL %s grant: ready=%b id=%0d addr=%h wd=%h w=%b r=%b, required ready=%b id=%0d addr=%h wd=%h w=%b",
                     tag, req_ready, grant_id, mem_addr, mem_wdata, mem_write, mem_read, one, w, ea, ed, ew);
        end
        if (!keep) req_valid[w] = 1'b0;
        r    = (done_at >= 1 && done_at <= TO) ? done_at + 1 : TO + 1;
        eerr = !(done_at >= 1 && done_at <= TO);
        erd  = eerr ? '1 : rdata;
        for (int e = 1; e <= r + 1; e++) begin
            mem_done  = (e == 1 && spur) || (done_at >= 1 && e == done_at + 1);
            mem_rdata = (done_at >= 1 && e == done_at + 1) ? rdata : DW'($urandom);
            tick();
            mem_done = 1'b0;
            if (e <= r) begin
                total++;
                if ({mem_read, mem_write, mem_addr, mem_wdata, req_ready} !== {2'b00, ea, ed, {NREQ{1'b0}}}) begin
                    bad++;
                    $display("FAIL %s hold c%0d: r=%b w=%b addr=%h wd=%h ready=%b, required 0 0 %h %h 0",
                             tag, e, mem_read, mem_write, mem_addr, mem_wdata, req_ready, ea, ed);
                end
            end
            total++;
            if (e < r) begin
                if ({resp_valid, busy} !== {{NREQ{1'b0}}, 1'b1}) begin
                    bad++;
                    $display("FAIL %s wait c%0d: resp_valid=%b busy=%b, required 0 1", tag, e, resp_valid, busy);
                end
            end else if (e == r) begin
                if ({resp_valid, resp_err, resp_rdata, busy, grant_id} !== {one, eerr, erd, 1'b1, 2'(w)}) begin
                    bad++;
                    $display("FAIL %s resp c%0d: valid=%b err=%b rdata=%h busy=%b id=%0d, required %b %b %h 1 %0d",
                             tag, e, resp_valid, resp_err, resp_rdata, busy, grant_id, one, eerr, erd, w);
                end
            end else begin
                if ({resp_valid, busy, resp_err, resp_rdata} !== {{NREQ{1'b0}}, 1'b0, eerr, erd}) begin
                    bad++;
                    $display("FAIL %s idle-after: valid=%b busy=%b err=%b rdata=%h, required 0 0 %b %h",
                             tag, resp_valid, busy, resp_err, resp_rdata, eerr, erd);
                end
            end
        end
        exp_last = w;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_done = 1'b0;
        repeat (3) tick();
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, busy, grant_id, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b busy=%b id=%0d r=%b w=%b addr=%h wd=%h, required all 0",
                     req_ready, resp_valid, resp_rdata, resp_err, busy, grant_id, mem_read, mem_write, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        exp_last = NREQ - 1;
        tick();
    endtask

    task automatic test_fairness();
        int w, gap;
        int order[4] = '{0, 1, 0, 1};
        set_req(0, 1'b0, 22'h01_0000, 16'h0000);
        set_req(1, 1'b1, 22'h02_0000, 16'h5A5A);
        for (int n = 0; n < 4; n++) begin
            run_op("fair", 3, 16'(16'h1000 + n), 1'b1, 1'b0, w, gap);
            total++;
            if (w !== order[n] || (n > 0 && gap !== 1)) begin
                bad++;
                $display("FAIL fair_order op%0d: owner=%0d gap=%0d, required owner=%0d gap=1", n, w, gap, order[n]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_read();
        int w, gap;
        set_req(0, 1'b0, 22'h000123, 16'h0000);
        run_op("read0", 7, 16'hBEEF, 1'b0, 1'b0, w, gap);
    endtask

    task automatic test_write();
        int w, gap;
        set_req(1, 1'b1, 22'h000AAA, 16'h1234);
        run_op("write1", 5, 16'h7777, 1'b0, 1'b1, w, gap);
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL write1_owner: owner=%0d, required 1", w);
        end
    endtask

    task automatic test_timeout();
        int w, gap;
        set_req(0, 1'b0, 22'h3F_FFFF, 16'h0000);
        run_op("timeout", 0, 16'h0000, 1'b0, 1'b0, w, gap);
        set_req(1, 1'b0, 22'h00_0042, 16'h0000);
        run_op("after_timeout", 4, 16'hC0DE, 1'b0, 1'b0, w, gap);
    endtask

    task automatic test_coincident();
        int w, gap;
        set_req(0, 1'b0, 22'h12_3456, 16'h0000);
        run_op("coincident", TO, 16'hA55A, 1'b0, 1'b0, w, gap);
    endtask

    task automatic test_idle_done();
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_done = 1'b0;
        tick();
        total++;
        if ({busy, resp_valid, mem_read, mem_write} !== '0) begin
            bad++;
            $display("FAIL idle_done: busy=%b valid=%b r=%b w=%b, required all 0", busy, resp_valid, mem_read, mem_write);
        end
    endtask

    task automatic test_reset_mid();
        int w, gap;
        bit seen;
        set_req(0, 1'b0, 22'h00_0777, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = mem_read | mem_write;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rstmid_strobe: no strobe, required one");
        end
        req_valid = '0;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, busy, grant_id, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: busy=%b addr=%h valid=%b id=%0d, required all 0", busy, mem_addr, resp_valid, grant_id);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        reset = 1'b0;
        exp_last = NREQ - 1;
        tick();
        total++;
        if ({busy, resp_valid} !== '0) begin
            bad++;
            $display("FAIL rstmid_quiet: busy=%b valid=%b, required 0 0", busy, resp_valid);
        end
        set_req(1, 1'b0, 22'h2A_AAAA, 16'h0000);
        run_op("rst_req1", 2, 16'h0101, 1'b0, 1'b0, w, gap);
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL rst_req1_owner: owner=%0d, required 1", w);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_last = NREQ - 1;
        set_req(0, 1'b0, 22'h11_1111, 16'h0000);
        set_req(1, 1'b1, 22'h22_2222, 16'h2222);
        run_op("rst_both", 3, 16'h0202, 1'b0, 1'b0, w, gap);
        total++;
        if (w !== 0) begin
            bad++;
            $display("FAIL rst_both_owner: owner=%0d, required 0", w);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int w, gap, pick, dn;
        for (int n = 0; n < 30; n++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                req_write[i]          = 1'($urandom);
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
            pick = $urandom_range(0, 9);
            dn = (pick == 0) ? 0 : (pick == 1) ? TO : $urandom_range(1, TO + 3);
            run_op("random", dn, DW'($urandom), 1'($urandom), 1'($urandom), w, gap);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_read();
        test_write();
        test_timeout();
        test_coincident();
        test_idle_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
